axi_slv_rd_ctrl: RTL and testbench
==================================

# axi_slv_rd_ctrl

AXI4 slave-side read controller that terminates the AR/R channels driven by the master read controller and converts each burst into single-beat reads of a synchronous SRAM-style memory port. It sits directly downstream of the master read path. It accepts one outstanding AR at a time, computes FIXED/INCR/WRAP beat addresses, and returns R beats with RID, RRESP and RLAST.

## Interface
- ID_W, 4, AXI ID width
- ADDR_W, 32, byte address width
- DATA_W, 32, data width (8·2^n, n=0..7)
- LEN_W, 8, AxLEN width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset (one clock, sync active-high reset: fixed)
- axi_slv_arvalid  in  1  AR valid
- axi_slv_arready  out  1  AR ready
- axi_slv_arid  in  ID_W  AR ID
- axi_slv_araddr  in  ADDR_W  start byte address
- axi_slv_arlen  in  LEN_W  beats−1
- axi_slv_arsize  in  3  log2 bytes/beat
- axi_slv_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- axi_slv_rvalid  out  1  R valid
- axi_slv_rready  in  1  R ready
- axi_slv_rid  out  ID_W  captured ARID
- axi_slv_rdata  out  DATA_W  read data
- axi_slv_rresp  out  2  00 OKAY, 10 SLVERR
- axi_slv_rlast  out  1  final beat
- mem_rd_en  out  1  one-cycle memory read strobe
- mem_rd_addr  out  ADDR_W  byte address of current beat
- mem_rd_data  in  DATA_W  valid the cycle after mem_rd_en, held until next mem_rd_en

## Operation
- States: IDLE, RD, RESP.
- IDLE: arready=1. On arvalid&arready, capture id, addr, len, size, burst into registers; clear beat_cnt; compute err = (burst==11) | (2^size > DATA_W/8) | (burst==WRAP & len∉{1,3,7,15}); → RD.
- RD: mem_rd_en=1 with mem_rd_addr=cur_addr, unless err (then mem_rd_en=0). Unconditionally → RESP.
- RESP: rvalid=1; rdata=mem_rd_data (0 when err); rresp=err?10:00; rid=captured id; rlast=(beat_cnt==len_r). Hold all R outputs stable while rready=0. On rvalid&rready: if rlast → IDLE, else beat_cnt+1, update cur_addr, → RD.
- Address update, bytes=2^size, aligned=cur_addr with low size bits cleared:
  - FIXED: cur_addr unchanged every beat.
  - INCR: aligned+bytes; first beat uses unaligned araddr as given. Plain ADDR_W modulo, no 4 KB check.
  - WRAP: total=bytes·(len+1); base=cur_addr & ~(total−1); next=base | ((aligned+bytes) & (total−1)).
- An error burst still produces exactly len+1 beats, all SLVERR, with no memory access.
- Only one burst is in flight; arready=0 in RD and RESP.

## Timing
- Reset (rst=1 at a clock edge): state=IDLE, arready=0 while rst high, rvalid=0, rlast=0, rresp=00, rid=0, mem_rd_en=0, beat_cnt=0, captured registers=0. arready=1 from the first cycle after rst deasserts.
- rst asserted mid-burst aborts the burst; no further R beats for it are produced.
- AR handshake in cycle t: mem_rd_en in t+1; first rvalid in t+2.
- Each beat takes 2 cycles minimum (RD, RESP); each rready-low cycle adds one.
- After the last-beat handshake in cycle u, arready=1 in u+1.
- arvalid while busy is ignored; the master holds it.
- rvalid never drops without a handshake.
- mem_rd_en is a single-cycle pulse per beat.

## Test plan
- INCR, araddr=0x100, len=3, size=2, id=5, rready=1 → mem_rd_addr 0x100,0x104,0x108,0x10C; rvalid at t+2,t+4,t+6,t+8; rid=5; rlast on 4th beat only; rresp=00.
- WRAP, araddr=0x38, len=3, size=2 → addresses 0x38,0x3C,0x30,0x34.
- FIXED, araddr=0x20, len=2 → mem_rd_addr=0x20 on all 3 beats.
- INCR, unaligned araddr=0x103, size=2, len=1 → 0x103 then 0x104.
- Backpressure: rready low for 3 cycles on beat 1 → rdata/rlast/rid stable; no extra mem_rd_en.
- Errors:
  - burst=11, len=1 → 2 SLVERR beats, mem_rd_en never high, rdata=0.
  - WRAP with len=2 → SLVERR.
- Reset mid-burst after beat 0 → rvalid=0 the next cycle; arready=1 after rst drops; a new burst completes correctly.

Source files
------------

// File: rtl/axi_slv_rd_ctrl.sv
// ---------------------------------------------------------------------------
// axi_slv_rd_ctrl
//   AXI4 slave-side read controller. Accepts one AR burst at a time and
//   breaks it into single-beat reads of a synchronous SRAM-style port,
//   returning one R beat per memory read (FIXED / INCR / WRAP addressing).
//   Illegal bursts (reserved burst type, oversize beat, bad WRAP length)
//   still return len+1 beats, all SLVERR, without touching memory.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   axi_slv_ar*              AR channel (valid/ready, id, addr, len, size, burst)
//   axi_slv_r*               R channel (valid/ready, id, data, resp, last)
//   mem_rd_en / mem_rd_addr  one-cycle read strobe and byte address per beat
//   mem_rd_data              read data, valid the cycle after mem_rd_en and
//                            held until the next mem_rd_en
// ---------------------------------------------------------------------------
module axi_slv_rd_ctrl #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axi_slv_arvalid,
    output logic              axi_slv_arready,
    input  logic [ID_W-1:0]   axi_slv_arid,
    input  logic [ADDR_W-1:0] axi_slv_araddr,
    input  logic [LEN_W-1:0]  axi_slv_arlen,
    input  logic [2:0]        axi_slv_arsize,
    input  logic [1:0]        axi_slv_arburst,
    output logic              axi_slv_rvalid,
    input  logic              axi_slv_rready,
    output logic [ID_W-1:0]   axi_slv_rid,
    output logic [DATA_W-1:0] axi_slv_rdata,
    output logic [1:0]        axi_slv_rresp,
    output logic              axi_slv_rlast,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_err;
    logic [LEN_W-1:0]  r_beat_cnt;

    logic              w_ar_hs;
    logic              w_beat_hs;
    logic              w_last;
    logic              w_ar_err;
    logic              w_wrap_len_ok;

    logic [ADDR_W-1:0] w_bytes;
    logic [ADDR_W-1:0] w_aligned;
    logic [ADDR_W-1:0] w_incr_addr;
    logic [ADDR_W-1:0] w_wrap_mask;
    logic [ADDR_W-1:0] w_wrap_addr;
    logic [ADDR_W-1:0] w_addr_nxt;

    // ------------------------------------------------------------------
    // Burst legality, evaluated on the incoming AR fields
    // ------------------------------------------------------------------
    assign w_wrap_len_ok = (axi_slv_arlen == LEN_W'(1))  ||
                           (axi_slv_arlen == LEN_W'(3))  ||
                           (axi_slv_arlen == LEN_W'(7))  ||
                           (axi_slv_arlen == LEN_W'(15));

    assign w_ar_err = (axi_slv_arburst == 2'b11) ||
                      (axi_slv_arsize > MAX_SIZE) ||
                      ((axi_slv_arburst == 2'b10) && !w_wrap_len_ok);

    // ------------------------------------------------------------------
    // Next beat address
    // ------------------------------------------------------------------
    assign w_bytes     = ADDR_W'(1) << r_size;
    assign w_aligned   = r_addr & ~(w_bytes - ADDR_W'(1));
    assign w_incr_addr = w_aligned + w_bytes;

    // WRAP lengths are 2/4/8/16 beats, so the wrap span bytes*(len+1) is a
    // power of two and can be formed with a shift.
    assign w_wrap_mask = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);
    assign w_wrap_addr = (r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);

    always_comb begin
        w_addr_nxt = r_addr;
        case (r_burst)
            2'b01:   w_addr_nxt = w_incr_addr;
            2'b10:   w_addr_nxt = w_wrap_addr;
            default: w_addr_nxt = r_addr;
        endcase
    end

    assign w_last    = (r_beat_cnt == r_len);
    assign w_ar_hs   = axi_slv_arvalid & axi_slv_arready;
    assign w_beat_hs = axi_slv_rvalid & axi_slv_rready;

    // ------------------------------------------------------------------
    // State and burst context registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_err      <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_ar_hs) begin
                r_id       <= axi_slv_arid;
                r_addr     <= axi_slv_araddr;
                r_len      <= axi_slv_arlen;
                r_size     <= axi_slv_arsize;
                r_burst    <= axi_slv_arburst;
                r_err      <= w_ar_err;
                r_beat_cnt <= '0;
            end
            if ((r_state == ST_RESP) && w_beat_hs && !w_last) begin
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                r_addr     <= w_addr_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and channel outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        axi_slv_arready = 1'b0;
        axi_slv_rvalid  = 1'b0;
        axi_slv_rlast   = 1'b0;
        axi_slv_rresp   = 2'b00;
        mem_rd_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Held low while reset is asserted so no AR is taken then.
                axi_slv_arready = ~rst;
                if (axi_slv_arvalid && !rst) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                mem_rd_en   = ~r_err;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                axi_slv_rvalid = 1'b1;
                axi_slv_rlast  = w_last;
                axi_slv_rresp  = r_err ? 2'b10 : 2'b00;
                if (axi_slv_rready) begin
                    w_state_nxt = w_last ? ST_IDLE : ST_RD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory holds its data until the next strobe, and no strobe is issued
    // in RESP, so rdata stays stable under backpressure without a register.
    assign axi_slv_rdata = ((r_state == ST_RESP) && !r_err) ? mem_rd_data : '0;
    assign axi_slv_rid   = r_id;
    assign mem_rd_addr   = r_addr;

endmodule

// File: tb/tb_axi_slv_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_slv_rd_ctrl
//   Self-checking bench for axi_slv_rd_ctrl. Beat addresses, error status and
//   read data come from a closed-form burst model; a small memory model
//   answers mem_rd_en with an address hash.
// ---------------------------------------------------------------------------
module tb_axi_slv_rd_ctrl;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              axi_slv_arvalid;
    logic              axi_slv_arready;
    logic [ID_W-1:0]   axi_slv_arid;
    logic [ADDR_W-1:0] axi_slv_araddr;
    logic [LEN_W-1:0]  axi_slv_arlen;
    logic [2:0]        axi_slv_arsize;
    logic [1:0]        axi_slv_arburst;
    logic              axi_slv_rvalid;
    logic              axi_slv_rready;
    logic [ID_W-1:0]   axi_slv_rid;
    logic [DATA_W-1:0] axi_slv_rdata;
    logic [1:0]        axi_slv_rresp;
    logic              axi_slv_rlast;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    axi_slv_rd_ctrl #(
        .ID_W   (ID_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .axi_slv_arvalid (axi_slv_arvalid),
        .axi_slv_arready (axi_slv_arready),
        .axi_slv_arid    (axi_slv_arid),
        .axi_slv_araddr  (axi_slv_araddr),
        .axi_slv_arlen   (axi_slv_arlen),
        .axi_slv_arsize  (axi_slv_arsize),
        .axi_slv_arburst (axi_slv_arburst),
        .axi_slv_rvalid  (axi_slv_rvalid),
        .axi_slv_rready  (axi_slv_rready),
        .axi_slv_rid     (axi_slv_rid),
        .axi_slv_rdata   (axi_slv_rdata),
        .axi_slv_rresp   (axi_slv_rresp),
        .axi_slv_rlast   (axi_slv_rlast),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous memory: data appears the cycle after the strobe and holds.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_fn(mem_rd_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_err(input int unsigned len, input int unsigned size,
                                     input int unsigned burst);
        bit wrap_ok;
        wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
        return (burst == 3) || ((1 << size) > (DATA_W / 8)) || ((burst == 2) && !wrap_ok);
    endfunction

    function automatic logic [31:0] model_addr(input longint unsigned addr, input int unsigned len,
                                               input int unsigned size, input int unsigned burst,
                                               input int unsigned beat);
        longint unsigned bytes, aligned, total, lower;
        bytes   = longint'(1) << size;
        aligned = (addr / bytes) * bytes;
        if (beat == 0 || burst == 0) return addr[31:0];
        if (burst == 1) return 32'((aligned + beat * bytes) % (longint'(1) << 32));
        total = bytes * (len + 1);
        lower = (addr / total) * total;
        return 32'(lower + ((aligned - lower + beat * bytes) % total));
    endfunction

    // Pulses reset while the controller sits in the RD cycle of a burst.
    task automatic abort_burst();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_rvalid", 64'(axi_slv_rvalid), 64'd0);
        check("abort_arready", 64'(axi_slv_arready), 64'd0);
        check("abort_memen", 64'(mem_rd_en), 64'd0);
        check("abort_rid", 64'(axi_slv_rid), 64'd0);
        check("abort_rlast", 64'(axi_slv_rlast), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_arready_after", 64'(axi_slv_arready), 64'd1);
        check("abort_rvalid_after", 64'(axi_slv_rvalid), 64'd0);
        @(posedge clk); #1;
    endtask

    // Entered just after a rising edge with the DUT idle; leaves it the same.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int stall_beat, input int stall_n, input bit rnd_stall,
                             input int abort_beat);
        bit          err;
        int          stall;
        logic [31:0] ea;
        err = model_err(len, size, burst);
        axi_slv_arvalid = 1'b1;
        axi_slv_arid    = id;
        axi_slv_araddr  = addr;
        axi_slv_arlen   = len;
        axi_slv_arsize  = size;
        axi_slv_arburst = burst;
        @(negedge clk);
        check("ar_ready_idle", 64'(axi_slv_arready), 64'd1);
        @(posedge clk); #1;
        axi_slv_arvalid = 1'b0;
        axi_slv_araddr  = $urandom;
        axi_slv_arid    = 4'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abort_beat) begin
                abort_burst();
                return;
            end
            ea = model_addr(addr, len, size, burst, i);
            @(negedge clk);
            check("rd_rvalid", 64'(axi_slv_rvalid), 64'd0);
            check("rd_arready", 64'(axi_slv_arready), 64'd0);
            check("rd_memen", 64'(mem_rd_en), 64'(!err));
            if (!err) check("rd_addr", 64'(mem_rd_addr), 64'(ea));
            @(posedge clk); #1;
            stall = rnd_stall ? int'($urandom_range(0, 2)) : ((i == stall_beat) ? stall_n : 0);
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk);
                check("r_valid", 64'(axi_slv_rvalid), 64'd1);
                check("r_id", 64'(axi_slv_rid), 64'(id));
                check("r_resp", 64'(axi_slv_rresp), err ? 64'd2 : 64'd0);
                check("r_last", 64'(axi_slv_rlast), 64'(i == int'(len)));
                check("r_data", 64'(axi_slv_rdata), err ? 64'd0 : 64'(mem_fn(ea)));
                check("r_memen_quiet", 64'(mem_rd_en), 64'd0);
                check("r_arready", 64'(axi_slv_arready), 64'd0);
                axi_slv_rready = (s == stall);
                @(posedge clk); #1;
            end
            axi_slv_rready = 1'b0;
        end
        @(negedge clk);
        check("end_arready", 64'(axi_slv_arready), 64'd1);
        check("end_rvalid", 64'(axi_slv_rvalid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] b;
        logic [2:0] sz;
        logic [7:0] ln;
        rst             = 1'b1;
        axi_slv_arvalid = 1'b0;
        axi_slv_arid    = '0;
        axi_slv_araddr  = '0;
        axi_slv_arlen   = '0;
        axi_slv_arsize  = '0;
        axi_slv_arburst = '0;
        axi_slv_rready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_arready", 64'(axi_slv_arready), 64'd0);
        check("rst_rvalid", 64'(axi_slv_rvalid), 64'd0);
        check("rst_rlast", 64'(axi_slv_rlast), 64'd0);
        check("rst_rresp", 64'(axi_slv_rresp), 64'd0);
        check("rst_rid", 64'(axi_slv_rid), 64'd0);
        check("rst_memen", 64'(mem_rd_en), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_arready", 64'(axi_slv_arready), 64'd1);
        @(posedge clk); #1;

        run_burst(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0, -1);  // INCR
        run_burst(4'd2, 32'h38,  8'd3, 3'd2, 2'b10, -1, 0, 1'b0, -1);  // WRAP
        run_burst(4'd7, 32'h20,  8'd2, 3'd2, 2'b00, -1, 0, 1'b0, -1);  // FIXED
        run_burst(4'd1, 32'h103, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0, -1);  // unaligned INCR
        run_burst(4'd9, 32'h200, 8'd2, 3'd2, 2'b01,  1, 3, 1'b0, -1);  // backpressure
        run_burst(4'd3, 32'h40,  8'd1, 3'd2, 2'b11, -1, 0, 1'b0, -1);  // reserved burst
        run_burst(4'd4, 32'h40,  8'd2, 3'd2, 2'b10, -1, 0, 1'b0, -1);  // bad WRAP len
        run_burst(4'd6, 32'h40,  8'd0, 3'd3, 2'b01, -1, 0, 1'b0, -1);  // oversize beat
        run_burst(4'd8, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0, -1); // addr wraps
        run_burst(4'd10, 32'h300, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0, 1);  // reset mid-burst
        run_burst(4'd11, 32'h400, 8'd2, 3'd1, 2'b01, -1, 0, 1'b0, -1); // after abort

        for (int n = 0; n < 80; n++) begin
            b  = 2'($urandom_range(0, 3));
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if (b == 2'b10 && $urandom_range(0, 3) != 0) begin
                ln = 8'((1 << $urandom_range(1, 4)) - 1);
            end else begin
                ln = 8'($urandom_range(0, 7));
            end
            run_burst(4'($urandom), $urandom, ln, sz, b, -1, 0, 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
